// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed common-anode 7-segment scan controller with guard interval, LZ suppression and per-frame snapshot.
// Optional define SEG7_SCAN_BRIGHTNESS_EN adds a 4-bit PWM brightness input gating the active anode.
module seg7_scan_ctrl #(
    parameter int unsigned NUM_DIGITS  = 4,
    parameter int unsigned REFRESH_DIV = 50000,
    parameter int unsigned GUARD_TICKS = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    lz_en,
    output logic [6:0]              sseg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame
`ifdef SEG7_SCAN_BRIGHTNESS_EN
    ,
    input  logic [3:0]              brightness
`endif
);

    localparam int unsigned PW = $clog2(REFRESH_DIV);
    localparam int unsigned IW = $clog2(NUM_DIGITS);
    localparam logic [PW-1:0] PRESC_MAX = PW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_MAX   = IW'(NUM_DIGITS - 1);

    typedef enum logic {
        ST_SHOW  = 1'b0,
        ST_GUARD = 1'b1
    } state_t;

    logic [PW-1:0]           r_presc;
    state_t                  r_state;
    logic [3:0]              r_gcnt;
    logic [IW-1:0]           r_idx;
    logic [4*NUM_DIGITS-1:0] r_sh_digits;
    logic [NUM_DIGITS-1:0]   r_sh_dp;
    logic                    r_sh_lz;

    logic                    w_tick;
    logic                    w_guard_done;
    logic                    w_adv;
    logic                    w_wrap;
    logic [IW-1:0]           w_pos;
    logic                    w_lead_zero;
    logic                    w_suppress;
    logic [3:0]              w_nib;
    logic [NUM_DIGITS-1:0]   w_an_n;
    logic                    w_lit;

    function automatic logic [6:0] glyph(input logic [3:0] v);
        logic [6:0] g;
        unique case (v)
            4'h0: g = 7'b1000000;
            4'h1: g = 7'b1111001;
            4'h2: g = 7'b0100100;
            4'h3: g = 7'b0110000;
            4'h4: g = 7'b0011001;
            4'h5: g = 7'b0010010;
            4'h6: g = 7'b0000010;
            4'h7: g = 7'b1111000;
            4'h8: g = 7'b0000000;
            4'h9: g = 7'b0010000;
            4'hA: g = 7'b0001000;
            4'hB: g = 7'b0000011;
            4'hC: g = 7'b1000110;
            4'hD: g = 7'b0100001;
            4'hE: g = 7'b0000110;
            default: g = 7'b0001110;
        endcase
        return g;
    endfunction

    assign w_tick = en && (r_presc == PRESC_MAX);

    // Buses are laid out like the anodes: digit i sits at nibble/bit NUM_DIGITS-1-i.
    always_comb begin
        w_guard_done = ((32'(r_gcnt) + 32'd1) >= GUARD_TICKS);
        w_adv        = w_tick && ((r_state == ST_SHOW) ? (GUARD_TICKS == 0) : w_guard_done);
        w_wrap       = w_adv && (r_idx == IDX_MAX);
        w_pos        = IDX_MAX - r_idx;
        w_lead_zero  = 1'b1;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if ((i <= 32'(r_idx)) && (r_sh_digits[4*(NUM_DIGITS-1-i) +: 4] != 4'd0)) begin
                w_lead_zero = 1'b0;
            end
        end
        w_suppress = r_sh_lz && w_lead_zero && (r_idx != IDX_MAX);
        w_nib      = r_sh_digits[{w_pos, 2'b00} +: 4];
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            w_an_n[i] = (w_pos != IW'(i));
        end
    end

`ifdef SEG7_SCAN_BRIGHTNESS_EN
    logic [3:0] r_pwm;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pwm <= 4'd0;
        end else begin
            r_pwm <= r_pwm + 4'd1;
        end
    end

    assign w_lit = (r_pwm < brightness);
`else
    assign w_lit = 1'b1;
`endif

    // Prescaler, scan FSM, snapshot and registered pin drive.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_presc     <= '0;
            r_state     <= ST_GUARD;
            r_gcnt      <= 4'd0;
            r_idx       <= IDX_MAX;
            r_sh_digits <= '0;
            r_sh_dp     <= '0;
            r_sh_lz     <= 1'b0;
            an          <= '1;
            sseg        <= 7'h7F;
            dp          <= 1'b1;
            frame       <= 1'b0;
        end else begin
            r_presc <= (!en || w_tick) ? '0 : r_presc + PW'(1);

            if (w_adv) begin
                r_state <= ST_SHOW;
                r_gcnt  <= 4'd0;
                r_idx   <= (r_idx == IDX_MAX) ? '0 : r_idx + IW'(1);
            end else if (w_tick) begin
                if (r_state == ST_SHOW) begin
                    r_state <= ST_GUARD;
                    r_gcnt  <= 4'd0;
                end else begin
                    r_gcnt <= r_gcnt + 4'd1;
                end
            end

            if (w_wrap) begin
                r_sh_digits <= digits;
                r_sh_dp     <= dp_in;
                r_sh_lz     <= lz_en;
            end
            frame <= w_wrap;

            if (!en || (r_state == ST_GUARD)) begin
                an   <= '1;
                sseg <= 7'h7F;
                dp   <= 1'b1;
            end else begin
                an   <= w_lit ? w_an_n : '1;
                sseg <= w_suppress ? 7'h7F : glyph(w_nib);
                dp   <= ~r_sh_dp[w_pos];
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed scoreboard bench for seg7_scan_ctrl: NUM_DIGITS=4, REFRESH_DIV=4, GUARD_TICKS=1 (default build).
module tb_seg7_scan_ctrl;

    localparam int unsigned N  = 4;
    localparam int unsigned RD = 4;
    localparam int unsigned GT = 1;

    typedef logic [12:0] exp_t;
    localparam exp_t BLANK = {4'hF, 7'h7F, 1'b1, 1'b0};
    localparam exp_t PULSE = {4'hF, 7'h7F, 1'b1, 1'b1};

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic [15:0]  digits;
    logic [3:0]   dp_in;
    logic         lz_en;
    logic [6:0]   sseg;
    logic         dp;
    logic [3:0]   an;
    logic         frame;

    exp_t  q[$];
    int    n_pass  = 0;
    int    n_total = 0;
    string tag     = "none";

    always #5 clk = ~clk;

    seg7_scan_ctrl #(
        .NUM_DIGITS (N),
        .REFRESH_DIV(RD),
        .GUARD_TICKS(GT)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .digits(digits),
        .dp_in (dp_in),
        .lz_en (lz_en),
        .sseg  (sseg),
        .dp    (dp),
        .an    (an),
        .frame (frame)
    );

    function automatic logic [6:0] seg_of(input logic [3:0] v);
        case (v)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;
            4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;
            4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    task automatic push_blank(input int n);
        repeat (n) q.push_back(BLANK);
    endtask

    // Digit d (0 = leftmost) uses nibble/bit 3-d and anode an[3-d].
    task automatic push_show(input int d, input logic [15:0] dg, input logic [3:0] dpv,
                             input logic lz, input int n);
        logic [3:0] a;
        logic [3:0] nib;
        logic [6:0] s;
        logic       zero;
        a       = 4'hF;
        a[3-d]  = 1'b0;
        nib     = dg[4*(3-d) +: 4];
        zero    = 1'b1;
        for (int i = 0; i <= d; i++) begin
            if (dg[4*(3-i) +: 4] != 4'h0) zero = 1'b0;
        end
        s = (lz && zero && (d != 3)) ? 7'h7F : seg_of(nib);
        repeat (n) q.push_back({a, s, ~dpv[3-d], 1'b0});
    endtask

    task automatic push_frame(input logic [15:0] dg, input logic [3:0] dpv, input logic lz);
        for (int d = 0; d < 4; d++) begin
            push_show(d, dg, dpv, lz, 4);
            if (d < 3) begin
                push_blank(4);
            end else begin
                push_blank(3);
                q.push_back(PULSE);
            end
        end
    endtask

    task automatic check_now();
        exp_t o;
        exp_t e;
        o = {an, sseg, dp, frame};
        n_total = n_total + 1;
        if (q.size() == 0) begin
            $error("FAIL %s: observed an/sseg/dp/frame=%h, required a queued expectation", tag, o);
        end else begin
            e = q.pop_front();
            assert (o === e) n_pass = n_pass + 1;
            else $error("FAIL %s: observed an=%b sseg=%b dp=%b frame=%b, required an=%b sseg=%b dp=%b frame=%b",
                        tag, o[12:9], o[8:2], o[1], o[0], e[12:9], e[8:2], e[1], e[0]);
        end
    endtask

    task automatic run_check(input int n);
        repeat (n) begin
            @(negedge clk);
            check_now();
        end
    endtask

    initial begin
        rst    = 1'b0;
        en     = 1'b1;
        lz_en  = 1'b0;
        digits = 16'h1234;
        dp_in  = 4'b0000;

        tag = "reset";
        repeat (2) @(negedge clk);
        push_blank(1);
        check_now();

        rst = 1'b1;
        tag = "startup";
        push_blank(3);
        q.push_back(PULSE);
        run_check(4);

        tag = "f1_1234_midchange";
        push_frame(16'h1234, 4'b0000, 1'b0);
        run_check(14);
        digits = 16'h5678;
        dp_in  = 4'b0010;
        run_check(18);

        tag = "f2_5678_dp";
        push_frame(16'h5678, 4'b0010, 1'b0);
        run_check(14);
        digits = 16'h00A0;
        dp_in  = 4'b0011;
        lz_en  = 1'b1;
        run_check(18);

        tag = "f3_00A0_lz";
        push_frame(16'h00A0, 4'b0011, 1'b1);
        run_check(14);
        digits = 16'h0000;
        dp_in  = 4'b0000;
        run_check(18);

        tag = "f4_0000_lz";
        push_frame(16'h0000, 4'b0000, 1'b1);
        run_check(14);
        digits = 16'h0F09;
        run_check(18);

        tag = "f5_0F09_lz";
        push_frame(16'h0F09, 4'b0000, 1'b1);
        run_check(14);
        digits = 16'hBCDE;
        dp_in  = 4'b1000;
        lz_en  = 1'b0;
        run_check(18);

        tag = "f6_BCDE";
        push_frame(16'hBCDE, 4'b1000, 1'b0);
        run_check(14);
        digits = 16'h9876;
        dp_in  = 4'b0000;
        run_check(18);

        tag = "f7_en_pre";
        push_show(0, 16'h9876, 4'b0000, 1'b0, 4);
        push_blank(4);
        push_show(1, 16'h9876, 4'b0000, 1'b0, 4);
        push_blank(4);
        push_show(2, 16'h9876, 4'b0000, 1'b0, 2);
        run_check(18);
        en     = 1'b0;
        digits = 16'h4321;
        dp_in  = 4'b0100;
        tag    = "f7_en_low";
        push_blank(10);
        run_check(10);
        en  = 1'b1;
        tag = "f7_en_resume";
        push_show(2, 16'h9876, 4'b0000, 1'b0, 4);
        push_blank(4);
        push_show(3, 16'h9876, 4'b0000, 1'b0, 4);
        push_blank(3);
        q.push_back(PULSE);
        run_check(16);

        tag = "f8_pre_reset";
        push_show(0, 16'h4321, 4'b0100, 1'b0, 4);
        push_blank(2);
        run_check(6);
        rst = 1'b0;
        #1;
        tag = "async_reset";
        push_blank(1);
        check_now();
        push_blank(2);
        run_check(2);
        digits = 16'hE0D0;
        dp_in  = 4'b0101;
        lz_en  = 1'b1;
        rst    = 1'b1;
        tag    = "restart";
        push_blank(3);
        q.push_back(PULSE);
        run_check(4);
        tag = "f9_E0D0";
        push_frame(16'hE0D0, 4'b0101, 1'b1);
        run_check(32);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
